// File: rtl/mmio_uart_tx_if.sv
// Data-memory bus between the single-cycle datapath and the UART transmitter window.
interface mmio_uart_tx_if;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        write_enable;
  logic [31:0] read_data;
  logic        sel;

  // Datapath side drives address/store data and consumes the read mux inputs.
  modport master (
    output addr,
    output write_data,
    output write_enable,
    input  read_data,
    input  sel
  );

  // Peripheral side decodes the window and returns combinational read data.
  modport slave (
    input  addr,
    input  write_data,
    input  write_enable,
    output read_data,
    output sel
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: 16-byte register window, TX FIFO, serialiser FSM.
module mmio_uart_tx #(
  parameter logic [31:0] BaseAddr  = 32'h1000_0000,
  parameter int unsigned ClkDiv    = 16,
  parameter int unsigned FifoDepth = 8
) (
  input  logic          clk,
  input  logic          rst,
  mmio_uart_tx_if.slave bus,
  output logic          tx
);

  localparam int unsigned PtrW  = $clog2(FifoDepth);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned BaudW = $clog2(ClkDiv);

  localparam logic [1:0] OffTxData = 2'd0;
  localparam logic [1:0] OffStatus = 2'd1;
  localparam logic [1:0] OffCount  = 2'd2;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_d;
  logic [BaudW-1:0]  baud, baud_d;
  logic [2:0]        bit_idx, bit_idx_d;
  logic [7:0]        shift, shift_d;
  logic              tx_d;

  logic [7:0]        mem [FifoDepth];
  logic [PtrW-1:0]   wr_ptr, rd_ptr;
  logic [CntW-1:0]   count;
  logic              overflow;

  logic              full_c, empty_c, busy_c, baud_last_c;
  logic              pop_c, push_req_c, push_c, ovf_set_c, ovf_clr_c;
  logic              wr_hit_c;

  // Store data above the byte lane and the byte offset within a word carry no meaning here.
  logic              unused_bits;
  assign unused_bits = ^{bus.write_data[31:8], bus.write_data[2:0], bus.addr[1:0]};

  // Window decode and write qualification.
  assign bus.sel     = (bus.addr[31:4] == BaseAddr[31:4]);
  assign wr_hit_c    = bus.write_enable && bus.sel;
  assign push_req_c  = wr_hit_c && (bus.addr[3:2] == OffTxData);
  assign ovf_clr_c   = wr_hit_c && (bus.addr[3:2] == OffStatus) && bus.write_data[3];

  // FIFO flags; a push into a full FIFO only survives if a pop frees a slot on the same edge.
  assign full_c      = (count == CntW'(FifoDepth));
  assign empty_c     = (count == '0);
  assign busy_c      = (state != IDLE);
  assign push_c      = push_req_c && (!full_c || pop_c);
  assign ovf_set_c   = push_req_c && full_c && !pop_c;
  assign baud_last_c = (baud == BaudW'(ClkDiv - 1));

  // Combinational register read so loads complete in the same cycle.
  always_comb begin
    bus.read_data = '0;
    if (bus.sel) begin
      case (bus.addr[3:2])
        OffStatus: bus.read_data = {28'd0, overflow, busy_c, empty_c, full_c};
        OffCount:  bus.read_data = 32'(count);
        default:   bus.read_data = '0;
      endcase
    end
  end

  // Serialiser next-state: every non-idle state holds ClkDiv cycles; baud counter restarts on entry.
  always_comb begin
    state_d   = state;
    baud_d    = baud;
    bit_idx_d = bit_idx;
    shift_d   = shift;
    tx_d      = tx;
    pop_c     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty_c) begin
          pop_c   = 1'b1;
          shift_d = mem[rd_ptr];
          tx_d    = 1'b0;
          baud_d  = '0;
          state_d = START;
        end else begin
          tx_d = 1'b1;
        end
      end
      START: begin
        if (baud_last_c) begin
          tx_d      = shift[0];
          bit_idx_d = 3'd0;
          baud_d    = '0;
          state_d   = DATA;
        end else begin
          baud_d = baud + BaudW'(1);
        end
      end
      DATA: begin
        if (baud_last_c) begin
          baud_d = '0;
          if (bit_idx == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            shift_d   = {1'b0, shift[7:1]};
            tx_d      = shift[1];
            bit_idx_d = bit_idx + 3'd1;
          end
        end else begin
          baud_d = baud + BaudW'(1);
        end
      end
      STOP: begin
        if (baud_last_c) begin
          baud_d = '0;
          if (!empty_c) begin
            // Back-to-back frame: next start bit follows the stop bit directly.
            pop_c   = 1'b1;
            shift_d = mem[rd_ptr];
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud + BaudW'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        baud_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Serialiser state and line register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'd0;
      tx      <= 1'b1;
    end else begin
      state   <= state_d;
      baud    <= baud_d;
      bit_idx <= bit_idx_d;
      shift   <= shift_d;
      tx      <= tx_d;
    end
  end

  // FIFO storage; contents are don't-care while the count is zero, so no reset.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= bus.write_data[7:0];
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + PtrW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PtrW'(1);
      end
      case ({push_c, pop_c})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow; a new drop on the same edge as a clear keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (ovf_set_c) begin
      overflow <= 1'b1;
    end else if (ovf_clr_c) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: directed scenarios plus random bus traffic vs a frame-level model.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int unsigned CD    = 4;
  localparam int unsigned D     = 8;
  localparam int unsigned FRAME = 10 * CD;

  logic clk;
  logic rst;
  logic tx;

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(.BaseAddr(BASE), .ClkDiv(CD), .FifoDepth(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .tx  (tx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: byte queue, frame in flight, elapsed cycles in that frame.
  logic [7:0] q_m [$];
  logic [7:0] exp_rx [$];
  logic [7:0] rx_q [$];
  bit         m_active;
  logic [7:0] m_byte;
  int         m_t;
  bit         m_ovf;
  bit         rx_kill = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit in_window(input logic [31:0] a);
    logic [31:0] b;
    b = BASE;
    return (a[31:4] == b[31:4]);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int n;
    n = q_m.size();
    if (!in_window(a)) return 32'd0;
    case (a[3:2])
      2'd1: return {28'd0, m_ovf, m_active, (n == 0), (n == int'(D))};
      2'd2: return 32'(n);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic model_tx();
    int k;
    if (!m_active) return 1'b1;
    k = m_t / int'(CD);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_byte[k-1];
  endfunction

  task automatic model_reset();
    q_m.delete();
    m_active = 1'b0;
    m_t      = 0;
    m_ovf    = 1'b0;
  endtask

  // One rising edge of the model, from pre-edge state and the bus inputs.
  task automatic model_edge(input logic [31:0] a, input logic [31:0] wd, input logic we);
    int  pre;
    bit  frame_end, pop, push, clr;
    pre       = q_m.size();
    frame_end = m_active && (m_t == int'(FRAME) - 1);
    pop       = (pre > 0) && (!m_active || frame_end);
    push      = we && in_window(a) && (a[3:2] == 2'd0);
    clr       = we && in_window(a) && (a[3:2] == 2'd1) && wd[3];
    if (frame_end) begin
      exp_rx.push_back(m_byte);
      m_active = 1'b0;
    end else if (m_active) begin
      m_t++;
    end
    if (pop) begin
      m_byte   = q_m.pop_front();
      m_active = 1'b1;
      m_t      = 0;
    end
    if (clr) m_ovf = 1'b0;
    if (push) begin
      if (pre < int'(D) || pop) q_m.push_back(wd[7:0]);
      else m_ovf = 1'b1;
    end
  endtask

  // One bus cycle: drive at negedge, check decode/read pre-edge, step model, check tx post-edge.
  task automatic cycle(input logic [31:0] a, input logic [31:0] wd, input logic we);
    @(negedge clk);
    bus.addr         = a;
    bus.write_data   = wd;
    bus.write_enable = we;
    #1;
    check_eq("sel", bus.sel, in_window(a));
    check_eq("read_data", bus.read_data, model_read(a));
    @(posedge clk);
    model_edge(a, wd, we);
    #1;
    check_eq("tx", tx, model_tx());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(32'h0, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    bus.addr         = 32'h0;
    bus.write_data   = 32'h0;
    bus.write_enable = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("rst_tx_async", tx, 1'b1);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    model_edge(bus.addr, bus.write_data, bus.write_enable);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      cycle(BASE + 32'h4, 32'h0, 1'b0);
      if (bus.read_data[2:0] == 3'b010) break;
    end
    check_eq("idle_status", bus.read_data & 32'h7, 32'h2);
  endtask

  task automatic compare_rx();
    check_eq("rx_count", rx_q.size(), exp_rx.size());
    while (rx_q.size() > 0 && exp_rx.size() > 0) begin
      check_eq("rx_byte", rx_q.pop_front(), exp_rx.pop_front());
    end
    rx_q.delete();
    exp_rx.delete();
  endtask

  // Line receiver: detects a start bit and samples the first cycle of each following bit.
  initial begin
    logic [7:0] rb;
    logic       stop_b;
    rb = 8'h0;
    stop_b = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (rst === 1'b0 && tx === 1'b0) begin
        for (int k = 1; k <= 9; k++) begin
          repeat (CD) @(posedge clk);
          #2;
          if (k <= 8) rb[k-1] = tx;
          else stop_b = tx;
        end
        if (rx_kill) begin
          rx_kill = 1'b0;
        end else begin
          rx_q.push_back(rb);
          check_eq("rx_stop_bit", stop_b, 1'b1);
        end
      end
    end
  end

  initial begin
    logic [9:0]  frame_bits;
    logic [31:0] a, wd;
    int          busy_n;
    int          r, wr_pct;

    rst = 1'b1;
    do_reset();

    // Reset state.
    check_eq("reset_tx", tx, 1'b1);
    cycle(BASE + 32'h4, 32'h0, 1'b0);
    check_eq("reset_status", bus.read_data, 32'h2);
    cycle(BASE + 32'h8, 32'h0, 1'b0);
    check_eq("reset_count", bus.read_data, 32'h0);

    // Single byte 0xA5: start bit one edge after the write, then LSB-first data, stop.
    cycle(BASE, 32'hA5, 1'b1);
    check_eq("a5_no_bypass", tx, 1'b1);
    frame_bits = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < int'(FRAME); i++) begin
      idle(1);
      check_eq("a5_bit", tx, frame_bits[i / int'(CD)]);
    end
    cycle(BASE + 32'h4, 32'h0, 1'b0);
    check_eq("a5_status_idle", bus.read_data, 32'h2);
    compare_rx();

    // Back-to-back frames: busy stays high for three whole frames.
    cycle(BASE, 32'h01, 1'b1);
    cycle(BASE, 32'h02, 1'b1);
    cycle(BASE, 32'h03, 1'b1);
    busy_n = 0;
    for (int i = 0; i < 400; i++) begin
      cycle(BASE + 32'h4, 32'h0, 1'b0);
      if (bus.read_data[2]) busy_n++;
      else break;
    end
    check_eq("b2b_busy_cycles", busy_n + 2, 3 * FRAME);
    wait_idle(50);
    compare_rx();

    // Overflow: 10 writes from empty, one popped, eight queued, one dropped.
    for (int i = 0; i < 10; i++) cycle(BASE, 32'(8'h30 + i), 1'b1);
    cycle(BASE + 32'h4, 32'h0, 1'b0);
    check_eq("ovf_status", bus.read_data, 32'hD);
    cycle(BASE + 32'h4, 32'h8, 1'b1);
    check_eq("ovf_cleared", bus.read_data, 32'h5);
    wait_idle(600);
    check_eq("ovf_frames", rx_q.size(), 9);
    compare_rx();

    // Decode: out-of-window writes and the reserved offset change nothing.
    cycle(BASE + 32'h10, 32'h77, 1'b1);
    cycle(BASE - 32'h4, 32'h66, 1'b1);
    cycle(BASE + 32'hC, 32'h55, 1'b1);
    check_eq("decode_tx_idle", tx, 1'b1);
    cycle(BASE + 32'h8, 32'h0, 1'b0);
    check_eq("decode_count", bus.read_data, 32'h0);

    // Full FIFO with a pop on the same edge as a write.
    for (int i = 0; i < 9; i++) cycle(BASE, 32'(8'h40 + i), 1'b1);
    for (int i = 0; i < 100; i++) begin
      if (m_active && m_t == int'(FRAME) - 1) break;
      idle(1);
    end
    cycle(BASE, 32'h5A, 1'b1);
    cycle(BASE + 32'h8, 32'h0, 1'b0);
    check_eq("fullpop_count", bus.read_data, 32'd8);
    cycle(BASE + 32'h4, 32'h0, 1'b0);
    check_eq("fullpop_status", bus.read_data, 32'h5);
    wait_idle(600);
    compare_rx();

    // Random bus traffic, alternating light and heavy write phases.
    for (int i = 0; i < 3000; i++) begin
      wr_pct = ((i / 500) % 2 == 1) ? 30 : 3;
      r  = $urandom_range(0, 99);
      wd = $urandom;
      a  = BASE | 32'($urandom_range(0, 3));
      if (r < wr_pct)           cycle(a, wd, 1'b1);
      else if (r < wr_pct + 8)  cycle(a | 32'h4, wd, 1'b1);
      else if (r < wr_pct + 20) cycle(a | 32'h8, wd, $urandom_range(0, 1) == 1);
      else if (r < wr_pct + 32) cycle(a | 32'h4, wd, 1'b0);
      else if (r < wr_pct + 38) cycle(a | 32'hC, wd, 1'b1);
      else if (r < wr_pct + 46) cycle($urandom, wd, 1'b1);
      else                      cycle(32'h0, 32'h0, 1'b0);
    end
    cycle(BASE + 32'h4, 32'h8, 1'b1);
    wait_idle(600);
    compare_rx();

    // Reset in data bit 3 with two bytes queued.
    cycle(BASE, 32'hC3, 1'b1);
    cycle(BASE, 32'h11, 1'b1);
    cycle(BASE, 32'h22, 1'b1);
    for (int i = 0; i < 100; i++) begin
      if (m_active && m_t == 4 * int'(CD) + 1) break;
      idle(1);
    end
    #1;
    rx_kill = 1'b1;
    do_reset();
    cycle(BASE + 32'h4, 32'h0, 1'b0);
    check_eq("rst_status", bus.read_data, 32'h2);
    idle(3 * FRAME);
    check_eq("rst_no_frames", rx_q.size(), 0);
    compare_rx();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
